mem_arbiter: RTL and testbench

Two-port memory-bus arbiter and I/O decoder between two bus masters and the shared single-port RAM. Port 0 is the CPU and port 1 is the program loader/debug master. The block serialises their accesses, with round-robin priority on simultaneous requests. It decodes the 9-bit bus address into RAM space, an LED output register and a switch input register. It returns read data and a one-cycle acknowledge to the granted master.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/rr_arb2.sv | 15 +
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared bus constants and arbiter state encoding for the memory arbiter.
package mem_bus_pkg;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [8:0] DEF_LED_ADDR = 9'h100;
    localparam logic [8:0] DEF_SW_ADDR  = 9'h140;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DATA,
        RESP
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: a tie goes to the port that did not win last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory-bus arbiter with RAM / LED / switch address decode.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 9,
    parameter int unsigned          DATA_W   = 16,
    parameter int unsigned          RAM_AW   = 8,
    parameter logic [ADDR_W-1:0]    LED_ADDR = ADDR_W'(DEF_LED_ADDR),
    parameter logic [ADDR_W-1:0]    SW_ADDR  = ADDR_W'(DEF_SW_ADDR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [1:0]        m0_cmd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [1:0]        m1_cmd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_write,
    input  logic [DATA_W-1:0] ram_dout,
    input  logic [7:0]        sw,
    output logic [7:0]        led
);

    arb_state_t        state, state_nxt;
    logic [1:0]        req_vec, grant_vec;
    logic              last_grant, grant_q;
    logic [1:0]        cmd_q;
    logic [ADDR_W-1:0] addr_q;

    logic              start, win;
    logic [1:0]        win_cmd;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;

    logic              is_ram_q, is_led_q, is_sw_q;
    logic              ram_write_nxt, led_we;
    logic [1:0]        ack_nxt;
    logic [DATA_W-1:0] result;

    assign req_vec = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .req        (req_vec),
        .last_grant (last_grant),
        .grant      (grant_vec)
    );

    assign start     = (state == IDLE) && (|req_vec);
    assign win       = grant_vec[1];
    assign win_cmd   = win ? m1_cmd   : m0_cmd;
    assign win_addr  = win ? m1_addr  : m0_addr;
    assign win_wdata = win ? m1_wdata : m0_wdata;

    assign is_ram_q = ~addr_q[ADDR_W-1];
    assign is_led_q = (addr_q == LED_ADDR);
    assign is_sw_q  = (addr_q == SW_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req_vec) state_nxt = ACCESS;
            ACCESS:  state_nxt = DATA;
            DATA:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded one cycle early so every port is driven from a flop.
    always_comb begin
        ram_write_nxt = start && (win_cmd == MWRITE) && ~win_addr[ADDR_W-1];
        led_we        = (state == ACCESS) && (cmd_q == MWRITE) && is_led_q;
        ack_nxt       = '0;
        if (state == DATA) begin
            ack_nxt = grant_q ? 2'b10 : 2'b01;
        end
        result = '0;
        if (cmd_q == MREAD) begin
            if (is_ram_q) begin
                result = ram_dout;
            end else if (is_led_q) begin
                result = {{(DATA_W-8){1'b0}}, led};
            end else if (is_sw_q) begin
                result = {{(DATA_W-8){1'b0}}, sw};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            cmd_q      <= MNONE;
            addr_q     <= '0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_write  <= 1'b0;
            led        <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
        end else begin
            if (start) begin
                grant_q    <= win;
                last_grant <= win;
                cmd_q      <= win_cmd;
                addr_q     <= win_addr;
                ram_addr   <= win_addr[RAM_AW-1:0];
                ram_din    <= win_wdata;
            end
            ram_write <= ram_write_nxt;
            if (led_we) begin
                led <= ram_din[7:0];
            end
            m0_ack <= ack_nxt[0];
            m1_ack <= ack_nxt[1];
            if (ack_nxt[0]) begin
                m0_rdata <= result;
            end
            if (ack_nxt[1]) begin
                m1_rdata <= result;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a synchronous RAM model.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [1:0]  m0_cmd = 2'b00, m1_cmd = 2'b00;
    logic [8:0]  m0_addr = '0, m1_addr = '0;
    logic [15:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack;
    logic [15:0] m0_rdata, m1_rdata;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic        ram_write;
    logic [15:0] ram_dout;
    logic [7:0]  sw = 8'h00;
    logic [7:0]  led;

    logic [15:0] mem [0:255];
    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_arbiter #(
        .ADDR_W   (9),
        .DATA_W   (16),
        .RAM_AW   (8),
        .LED_ADDR (9'h100),
        .SW_ADDR  (9'h140)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (m0_req),
        .m0_cmd   (m0_cmd),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_cmd   (m1_cmd),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_write(ram_write),
        .ram_dout (ram_dout),
        .sw       (sw),
        .led      (led)
    );

    always #5 clk = ~clk;

    // Preload pattern: mem[i] = 16'h1100 ^ i.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h1100 ^ 16'(i);
        end else if (ram_write) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        step();
        step();
        preload = 1'b0;
        step();
        reset = 1'b0;

        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        chk("rst_m1_rdata", m1_rdata, 0);
        chk("rst_ram_write", ram_write, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_led", led, 0);

        // m0 RAM write
        m0_req = 1'b1; m0_cmd = 2'b10; m0_addr = 9'h005; m0_wdata = 16'hABCD;
        step();
        chk("wr_access_we", ram_write, 1);
        chk("wr_access_addr", ram_addr, 8'h05);
        chk("wr_access_din", ram_din, 16'hABCD);
        chk("wr_access_ack", m0_ack, 0);
        step();
        chk("wr_data_we", ram_write, 0);
        chk("wr_data_ack", m0_ack, 0);
        step();
        chk("wr_resp_ack", m0_ack, 1);
        chk("wr_resp_rdata", m0_rdata, 0);
        chk("wr_resp_m1ack", m1_ack, 0);
        m0_req = 1'b0;
        step();
        chk("wr_ack_drop", m0_ack, 0);

        // m0 RAM read back
        m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h005;
        step();
        chk("rd_access_we", ram_write, 0);
        chk("rd_access_addr", ram_addr, 8'h05);
        step();
        step();
        chk("rd_resp_ack", m0_ack, 1);
        chk("rd_resp_rdata", m0_rdata, 16'hABCD);
        chk("rd_resp_m1ack", m1_ack, 0);
        m0_req = 1'b0;
        step();
        chk("rd_ack_drop", m0_ack, 0);

        // Contention straight after reset: grants alternate 0,1,0,1
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h001;
        m1_req = 1'b1; m1_cmd = 2'b10; m1_addr = 9'h002; m1_wdata = 16'h1234;
        for (int t = 0; t < 4; t++) begin
            logic p;
            p = t[0];
            step();
            chk("arb_ram_write", ram_write, {31'd0, p});
            step();
            step();
            chk("arb_m0_ack", m0_ack, {31'd0, ~p});
            chk("arb_m1_ack", m1_ack, {31'd0, p});
            chk("arb_m0_rdata", m0_rdata, 16'h1101);
            if (p) chk("arb_m1_rdata", m1_rdata, 0);
            if (t == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            step();
        end
        chk("arb_m1_wrote_ram", mem[2], 16'h1234);

        // LED write, LED/switch/unmapped reads on m1
        m1_req = 1'b1; m1_cmd = 2'b10; m1_addr = 9'h100; m1_wdata = 16'h00A5;
        step();
        chk("led_wr_no_ram", ram_write, 0);
        step();
        chk("led_wr_value", led, 8'hA5);
        step();
        chk("led_wr_ack", m1_ack, 1);
        chk("led_wr_rdata", m1_rdata, 0);
        m1_req = 1'b0;
        step();

        sw = 8'h3C;
        m1_req = 1'b1; m1_cmd = 2'b01; m1_addr = 9'h140;
        step(); step(); step();
        chk("sw_rd_ack", m1_ack, 1);
        chk("sw_rd_rdata", m1_rdata, 16'h003C);
        m1_req = 1'b0;
        step();

        m1_req = 1'b1; m1_cmd = 2'b01; m1_addr = 9'h100;
        step(); step(); step();
        chk("led_rd_rdata", m1_rdata, 16'h00A5);
        m1_req = 1'b0;
        step();

        m1_req = 1'b1; m1_cmd = 2'b01; m1_addr = 9'h1FF;
        step(); step(); step();
        chk("unmap_rd_ack", m1_ack, 1);
        chk("unmap_rd_rdata", m1_rdata, 0);
        m1_req = 1'b0;
        step();

        // Reset during ACCESS of a RAM write
        m0_req = 1'b1; m0_cmd = 2'b10; m0_addr = 9'h010; m0_wdata = 16'h5555;
        step();
        chk("abort_we_before", ram_write, 1);
        reset = 1'b1;
        #1;
        chk("abort_we_async", ram_write, 0);
        chk("abort_led", led, 0);
        chk("abort_ack", m0_ack, 0);
        m0_req = 1'b0;
        step();
        reset = 1'b0;
        step(); step(); step();
        chk("abort_no_ack", m0_ack, 0);
        chk("abort_ram_kept", mem[16], 16'h1110);

        m0_req = 1'b1; m0_cmd = 2'b01; m0_addr = 9'h005;
        step(); step(); step();
        chk("post_rst_ack", m0_ack, 1);
        chk("post_rst_rdata", m0_rdata, 16'hABCD);
        m0_req = 1'b0;
        step();

        // MNONE on m0
        m0_req = 1'b1; m0_cmd = 2'b00; m0_addr = 9'h005;
        step();
        chk("none_no_we", ram_write, 0);
        step();
        chk("none_led", led, 0);
        step();
        chk("none_ack", m0_ack, 1);
        chk("none_rdata", m0_rdata, 0);
        m0_req = 1'b0;
        step();
        chk("none_ack_drop", m0_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
